// File: rtl/insn_decode_queue.sv
// rtl/insn_decode_queue.sv - RVV instruction decoder feeding a DEPTH-entry FIFO of decoded bundles.
// The head bundle is held in a dedicated register so outputs never see insn_in combinationally.
module insn_decode_queue #(
  parameter int         INSN_WIDTH = 32,
  parameter int         DEPTH      = 4,
  parameter logic [6:0] OPC_V      = 7'h57,
  parameter logic [6:0] OPC_LD     = 7'h07,
  parameter logic [6:0] OPC_ST     = 7'h27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INSN_WIDTH-1:0]   insn_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [6:0]              opcode_mjr,
  output logic [2:0]              opcode_mnr,
  output logic [4:0]              dest,
  output logic [4:0]              src_1,
  output logic [4:0]              src_2,
  output logic                    vm,
  output logic [5:0]              funct6,
  output logic [1:0]              mop,
  output logic                    mew,
  output logic [2:0]              nf,
  output logic [10:0]             zimm_11,
  output logic [1:0]              cfg_type,
  output logic [2:0]              insn_class,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] CLS_ILL    = 3'd0;
  localparam logic [2:0] CLS_VALU   = 3'd1;
  localparam logic [2:0] CLS_VCFG   = 3'd2;
  localparam logic [2:0] CLS_VLOAD  = 3'd3;
  localparam logic [2:0] CLS_VSTORE = 3'd4;

  function automatic logic [2:0] decode_class(input logic [6:0] opc, input logic [2:0] mnr);
    logic mem_width_ok;
    mem_width_ok = (mnr == 3'd0) || (mnr >= 3'd5);
    if (opc == OPC_V)                       return (mnr == 3'd7) ? CLS_VCFG : CLS_VALU;
    else if (opc == OPC_LD && mem_width_ok) return CLS_VLOAD;
    else if (opc == OPC_ST && mem_width_ok) return CLS_VSTORE;
    else                                    return CLS_ILL;
  endfunction

  logic [INSN_WIDTH-1:0] insn_mem_q  [DEPTH];
  logic [2:0]            class_mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [INSN_WIDTH-1:0] head_insn_q, head_insn_d;
  logic [2:0]            head_class_q, head_class_d;

  logic       push;
  logic       pop;
  logic [2:0] in_class;

  always_comb begin
    in_ready     = count_q < CW'(DEPTH);
    out_valid    = count_q != '0;
    push         = in_valid & in_ready & ~flush;
    pop          = out_valid & out_ready & ~flush;
    in_class     = decode_class(insn_in[6:0], insn_in[14:12]);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_insn_d  = head_insn_q;
    head_class_d = CLS_ILL;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // A push into a queue that is (or becomes) empty lands directly at the head.
    if (count_d != '0) begin
      if (push && count_q == CW'(pop)) begin
        head_insn_d  = insn_in;
        head_class_d = in_class;
      end else begin
        head_insn_d  = insn_mem_q[rd_ptr_d];
        head_class_d = class_mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_insn_q  <= '0;
      head_class_q <= CLS_ILL;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_insn_q  <= head_insn_d;
      head_class_q <= head_class_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem_q[wr_ptr_q]  <= insn_in;
      class_mem_q[wr_ptr_q] <= in_class;
    end
  end

  assign opcode_mjr = head_insn_q[6:0];
  assign opcode_mnr = head_insn_q[14:12];
  assign dest       = head_insn_q[11:7];
  assign src_1      = head_insn_q[19:15];
  assign src_2      = head_insn_q[24:20];
  assign vm         = head_insn_q[25];
  assign funct6     = head_insn_q[31:26];
  assign mop        = head_insn_q[27:26];
  assign mew        = head_insn_q[28];
  assign nf         = head_insn_q[31:29];
  assign zimm_11    = head_insn_q[30:20];
  assign cfg_type   = head_insn_q[31:30];
  assign insn_class = head_class_q;
  assign count      = count_q;

endmodule

// File: tb/tb_insn_decode_queue.sv
// tb/tb_insn_decode_queue.sv - randomized bench for insn_decode_queue against a queue-based model.
module tb_insn_decode_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] insn_in = '0;
  logic        in_ready, out_valid, vm, mew;
  logic [6:0]  opcode_mjr;
  logic [2:0]  opcode_mnr, nf, insn_class;
  logic [4:0]  dest, src_1, src_2;
  logic [5:0]  funct6;
  logic [1:0]  mop, cfg_type;
  logic [10:0] zimm_11;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [31:0] mq[$];

  insn_decode_queue #(.INSN_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .insn_in(insn_in), .out_valid(out_valid), .out_ready(out_ready),
    .opcode_mjr(opcode_mjr), .opcode_mnr(opcode_mnr), .dest(dest), .src_1(src_1),
    .src_2(src_2), .vm(vm), .funct6(funct6), .mop(mop), .mew(mew), .nf(nf),
    .zimm_11(zimm_11), .cfg_type(cfg_type), .insn_class(insn_class), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_class(input logic [31:0] i);
    logic [2:0] w;
    w = i[14:12];
    case (i[6:0])
      7'h57:   return (w == 3'd7) ? 3'd2 : 3'd1;
      7'h07:   return (w inside {3'd0, 3'd5, 3'd6, 3'd7}) ? 3'd3 : 3'd0;
      7'h27:   return (w inside {3'd0, 3'd5, 3'd6, 3'd7}) ? 3'd4 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return {r[31:7], 7'h57};
      1:       return {r[31:7], 7'h07};
      2:       return {r[31:7], 7'h27};
      3:       return 32'h0000_0013;
      default: return r;
    endcase
  endfunction

  task automatic compare();
    logic [31:0] e;
    check("count", 32'(count), 32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      e = mq[0];
      check("class", 32'(insn_class), 32'(model_class(e)));
      check("fields_a", {opcode_mjr, opcode_mnr, dest, src_1, src_2, vm, funct6},
            {e[6:0], e[14:12], e[11:7], e[19:15], e[24:20], e[25], e[31:26]});
      check("fields_b", 32'({mop, mew, nf, zimm_11, cfg_type}),
            32'({e[27:26], e[28], e[31:29], e[30:20], e[31:30]}));
    end else begin
      check("class_idle", 32'(insn_class), 32'd0);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    bit do_push, do_pop;
    in_valid  = v;
    insn_in   = ins;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() != 0);
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(ins);
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic [31:0] held;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fields", {opcode_mjr, opcode_mnr, dest, src_1, src_2, vm, funct6}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    compare();

    // T2 decode of vadd.vv v2,v2,v1
    step(1'b1, 32'h0220_8157, 1'b0, 1'b0);
    check("t2_class", 32'(insn_class), 32'd1);
    check("t2_dest", 32'(dest), 32'd2);
    check("t2_src_1", 32'(src_1), 32'd1);
    check("t2_src_2", 32'(src_2), 32'd2);
    check("t2_vm", 32'(vm), 32'd1);
    check("t2_funct6", 32'(funct6), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // T3 class sequence
    step(1'b1, 32'h0000_7057, 1'b0, 1'b0);
    step(1'b1, 32'h0200_6007, 1'b0, 1'b0);
    step(1'b1, 32'h0200_0027, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    check("t3_cls0", 32'(insn_class), 32'd2);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t3_cls1", 32'(insn_class), 32'd3);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t3_cls2", 32'(insn_class), 32'd4);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t3_cls3", 32'(insn_class), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // T4 full, fifth insn held until a pop frees a slot
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_insn(), 1'b0, 1'b0);
    held = rand_insn();
    step(1'b1, held, 1'b0, 1'b0);
    check("t4_count_full", 32'(count), 32'd4);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, held, 1'b1, 1'b0);
    check("t4_count_pop", 32'(count), 32'd3);
    step(1'b1, held, 1'b0, 1'b0);
    check("t4_count_refill", 32'(count), 32'd4);
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0);

    // T5 simultaneous push/pop across pointer wrap
    step(1'b1, rand_insn(), 1'b0, 1'b0);
    step(1'b1, rand_insn(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rand_insn(), 1'b1, 1'b0);
      check("t5_count", 32'(count), 32'd2);
    end
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // T1 asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, rand_insn(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_count", 32'(count), 32'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    compare();

    // T6 flush overrides push and pop
    for (int i = 0; i < 3; i++) step(1'b1, rand_insn(), 1'b0, 1'b0);
    step(1'b1, rand_insn(), 1'b1, 1'b1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_insn(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
